// File: rtl/chan_550_capture_pkg.sv
// Shared types and field offsets for the chan_550 capture trigger controller.
// The state encoding is visible to software through status_word.
package chan_550_capture_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } cap_state_t;

    localparam int ARM_BIT      = 0;
    localparam int FORCE_BIT    = 1;
    localparam int POST_LEN_LSB = 16;

    localparam int DONE_BIT  = 31;
    localparam int STATE_LSB = 28;

endpackage

// File: rtl/chan_550_capture_addr_gen.sv
// Capture write-address generator.
// It owns the wrapping write pointer, the saturating pre-fill count and the post-trigger countdown.
module chan_550_capture_addr_gen #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              wr_en,
    input  logic              load_rem,
    input  logic              count_post,
    input  logic [ADDR_W-1:0] post_len,
    input  logic [ADDR_W:0]   pre_len,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W:0]   fill_cnt,
    output logic [ADDR_W-1:0] remaining
);

    // wr_addr wraps naturally at 2^ADDR_W.
    // fill_cnt needs one extra bit because pre_len can equal the full depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr  <= '0;
            fill_cnt <= '0;
        end else if (clear) begin
            wr_addr  <= '0;
            fill_cnt <= '0;
        end else if (wr_en) begin
            wr_addr <= wr_addr + 1'b1;
            if (fill_cnt < pre_len) begin
                fill_cnt <= fill_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remaining <= '0;
        end else if (load_rem) begin
            remaining <= post_len;
        end else if (count_post && (remaining != '0)) begin
            remaining <= remaining - 1'b1;
        end
    end

endmodule

// File: rtl/chan_550_capture_trigger_ctrl.sv
// Threshold-triggered snapshot sequencer.
// It fills a circular capture BRAM with pre-trigger and post-trigger samples and reports the result in status_word.
module chan_550_capture_trigger_ctrl
    import chan_550_capture_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              user_clk,
    input  logic              user_rst_n,
    input  logic [31:0]       threshold,
    input  logic [31:0]       ctrl_word,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_data,
    output logic              bram_we,
    output logic [31:0]       status_word,
    output logic              done
);

    localparam int              CMP_W = (DATA_W > 32) ? DATA_W : 32;
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    cap_state_t        state, state_nxt;
    logic              arm, force_trig, arm_d, arm_edge, hit;
    logic [ADDR_W-1:0] post_len, wr_addr, remaining, trig_addr;
    logic [ADDR_W:0]   pre_len, fill_cnt;
    logic [CMP_W-1:0]  data_x, thr_x;
    logic              wr_en, trigger, clear_cnt, load_rem, count_post;
    logic              unused_ctrl;

    assign arm        = ctrl_word[ARM_BIT];
    assign force_trig = ctrl_word[FORCE_BIT];
    assign post_len   = ctrl_word[POST_LEN_LSB +: ADDR_W];
    assign pre_len    = DEPTH - {1'b0, post_len};
    assign arm_edge   = arm & ~arm_d;

    assign data_x = CMP_W'(data_in);
    assign thr_x  = CMP_W'(threshold);
    assign hit    = data_valid & (data_x >= thr_x);

    assign unused_ctrl = ^{ctrl_word[31:POST_LEN_LSB+ADDR_W], ctrl_word[POST_LEN_LSB-1:2]};

    chan_550_capture_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .clk        (user_clk),
        .rst_n      (user_rst_n),
        .clear      (clear_cnt),
        .wr_en      (wr_en),
        .load_rem   (load_rem),
        .count_post (count_post),
        .post_len   (post_len),
        .pre_len    (pre_len),
        .wr_addr    (wr_addr),
        .fill_cnt   (fill_cnt),
        .remaining  (remaining)
    );

    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Abort (arm low) takes priority over a trigger in the same ARMED cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (arm_edge) state_nxt = ARMED;
            ARMED: begin
                if (!arm) begin
                    state_nxt = IDLE;
                end else if (trigger) begin
                    state_nxt = (post_len == '0) ? DONE : CAPTURE;
                end
            end
            CAPTURE: if (data_valid && (remaining == ADDR_W'(1))) state_nxt = DONE;
            DONE:    if (arm_edge) state_nxt = ARMED;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        wr_en      = 1'b0;
        trigger    = 1'b0;
        clear_cnt  = 1'b0;
        load_rem   = 1'b0;
        count_post = 1'b0;
        case (state)
            IDLE, DONE: clear_cnt = arm_edge;
            ARMED: begin
                if (arm) begin
                    wr_en    = data_valid;
                    trigger  = (hit && (fill_cnt >= pre_len)) || force_trig;
                    load_rem = trigger;
                end
            end
            CAPTURE: begin
                wr_en      = data_valid;
                count_post = data_valid;
            end
            default: ;
        endcase
    end

    // Registered BRAM write port plus the arm edge detector and trigger position.
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            arm_d     <= 1'b0;
            trig_addr <= '0;
            bram_we   <= 1'b0;
            bram_addr <= '0;
            bram_data <= '0;
        end else begin
            arm_d   <= arm;
            bram_we <= wr_en;
            if (wr_en) begin
                bram_addr <= wr_addr;
                bram_data <= data_in;
            end
            if (trigger) begin
                trig_addr <= wr_addr;
            end
        end
    end

    assign done = (state == DONE);

    always_comb begin
        status_word                      = '0;
        status_word[ADDR_W-1:0]          = trig_addr;
        status_word[STATE_LSB +: 2]      = state;
        status_word[DONE_BIT]            = done;
    end

endmodule

// File: tb/tb_chan_550_capture_trigger_ctrl.sv
// Directed and randomized bench for chan_550_capture_trigger_ctrl with a capture-session reference model.
module tb_chan_550_capture_trigger_ctrl;

    logic        user_clk;
    logic        user_rst_n;
    logic [31:0] threshold;
    logic [31:0] ctrl_word;
    logic [31:0] data_in;
    logic        data_valid;
    logic [3:0]  bram_addr;
    logic [31:0] bram_data;
    logic        bram_we;
    logic [31:0] status_word;
    logic        done;

    int vecs = 0;
    int miscompares = 0;

    // Reference model: a session counts writes since arming; the address is that count mod 16.
    int         m_state;
    int         m_nwr;
    int         m_end;
    logic [3:0] m_trig;
    logic       m_arm_d;

    chan_550_capture_trigger_ctrl #(.ADDR_W(4), .DATA_W(32)) dut (
        .user_clk    (user_clk),
        .user_rst_n  (user_rst_n),
        .threshold   (threshold),
        .ctrl_word   (ctrl_word),
        .data_in     (data_in),
        .data_valid  (data_valid),
        .bram_addr   (bram_addr),
        .bram_data   (bram_data),
        .bram_we     (bram_we),
        .status_word (status_word),
        .done        (done)
    );

    initial user_clk = 1'b0;
    always #5 user_clk = ~user_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_nwr   = 0;
        m_end   = 0;
        m_trig  = 4'd0;
        m_arm_d = 1'b0;
    endtask

    task automatic set_ctrl(input logic arm, input logic frc, input int pl);
        ctrl_word = 32'((pl & 15) << 16) | {30'd0, frc, arm};
    endtask

    // One clock: drive inputs, advance the model, check every output after the edge.
    task automatic step(input logic v, input logic [31:0] d);
        logic       arm, frc, arm_edge, hit, exp_we;
        logic [3:0] exp_addr;
        int         pl;
        logic [31:0] exp_status;
        data_valid = v;
        data_in    = d;
        arm      = ctrl_word[0];
        frc      = ctrl_word[1];
        pl       = int'(ctrl_word[19:16]);
        arm_edge = arm && !m_arm_d;
        exp_we   = 1'b0;
        exp_addr = 4'd0;
        case (m_state)
            1: begin
                if (!arm) begin
                    m_state = 0;
                end else begin
                    hit = v && (d >= threshold);
                    if (v) begin
                        exp_we   = 1'b1;
                        exp_addr = 4'(m_nwr % 16);
                    end
                    if ((hit && (m_nwr >= 16 - pl)) || frc) begin
                        m_trig  = 4'(m_nwr % 16);
                        m_end   = m_nwr + (v ? 1 : 0) + pl;
                        m_state = (pl == 0) ? 3 : 2;
                    end
                    if (v) m_nwr++;
                end
            end
            2: begin
                if (v) begin
                    exp_we   = 1'b1;
                    exp_addr = 4'(m_nwr % 16);
                    m_nwr++;
                    if (m_nwr == m_end) m_state = 3;
                end
            end
            default: begin
                if (arm_edge) begin
                    m_state = 1;
                    m_nwr   = 0;
                end
            end
        endcase
        m_arm_d = arm;
        exp_status = {(m_state == 3), 1'b0, 2'(m_state), 24'd0, m_trig};
        @(posedge user_clk);
        #1;
        check("bram_we", {31'd0, bram_we}, {31'd0, exp_we});
        if (exp_we) begin
            check("bram_addr", {28'd0, bram_addr}, {28'd0, exp_addr});
            check("bram_data", bram_data, d);
        end
        check("status_word", status_word, exp_status);
        check("done", {31'd0, done}, {31'd0, (m_state == 3)});
    endtask

    task automatic rearm(input int pl);
        set_ctrl(1'b0, 1'b0, pl);
        step(1'b0, 32'd0);
        set_ctrl(1'b1, 1'b0, pl);
        step(1'b0, 32'd0);
    endtask

    task automatic run_to_done(input int maxc);
        for (int i = 0; i < maxc && m_state != 3; i++) begin
            step(1'($urandom_range(0, 3) != 0), $urandom);
        end
    endtask

    initial begin
        user_rst_n = 1'b0;
        threshold  = 32'd100;
        ctrl_word  = 32'd0;
        data_in    = 32'd0;
        data_valid = 1'b0;
        model_reset();
        repeat (3) @(posedge user_clk);
        #1;
        check("reset_we", {31'd0, bram_we}, 32'd0);
        check("reset_addr", {28'd0, bram_addr}, 32'd0);
        check("reset_data", bram_data, 32'd0);
        check("reset_status", status_word, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        @(negedge user_clk);
        user_rst_n = 1'b1;
        step(1'b0, 32'd0);

        // Basic trigger: 20 sub-threshold samples wrap the buffer, the 21st write triggers.
        set_ctrl(1'b1, 1'b0, 4);
        step(1'b0, 32'd0);
        for (int i = 0; i < 20; i++) step(1'b1, 32'(i));
        step(1'b1, 32'd150);
        check("basic_trig_addr", {28'd0, status_word[3:0]}, 32'd4);
        check("basic_state", {30'd0, status_word[29:28]}, 32'd2);
        run_to_done(40);
        check("basic_done", {31'd0, done}, 32'd1);
        check("basic_status_state", {30'd0, status_word[29:28]}, 32'd3);

        // Pre-fill gate: an early hit is ignored until 12 writes have landed.
        rearm(4);
        for (int i = 0; i < 12; i++) step(1'b1, (i == 2) ? 32'd200 : $urandom_range(0, 99));
        check("prefill_armed", {30'd0, status_word[29:28]}, 32'd1);
        step(1'b1, $urandom_range(100, 1000));
        check("prefill_trig_addr", {28'd0, status_word[3:0]}, 32'd12);
        run_to_done(40);
        check("prefill_done", {31'd0, done}, 32'd1);

        // Force trigger with no valid sample.
        rearm(4);
        set_ctrl(1'b1, 1'b1, 4);
        step(1'b0, 32'd0);
        check("force_trig_addr", {28'd0, status_word[3:0]}, 32'd0);
        check("force_state", {30'd0, status_word[29:28]}, 32'd2);
        set_ctrl(1'b1, 1'b0, 4);
        run_to_done(40);
        check("force_done", {31'd0, done}, 32'd1);

        // Abort, then arm and force together from IDLE.
        rearm(6);
        for (int i = 0; i < 5; i++) step(1'b1, $urandom_range(0, 50));
        set_ctrl(1'b0, 1'b0, 6);
        step(1'b1, 32'd7);
        check("abort_state", {30'd0, status_word[29:28]}, 32'd0);
        step(1'b1, 32'd500);
        set_ctrl(1'b1, 1'b1, 6);
        step(1'b1, 32'd600);
        check("arm_force_state", {30'd0, status_word[29:28]}, 32'd1);
        step(1'b1, 32'd700);
        check("rearm_trig_addr", {28'd0, status_word[3:0]}, 32'd0);
        set_ctrl(1'b1, 1'b0, 6);
        run_to_done(60);

        // post_len = 0: the trigger write is the only post-fill write.
        rearm(0);
        for (int i = 0; i < 16; i++) step(1'b1, $urandom_range(0, 99));
        step(1'b1, 32'd500);
        check("pl0_done", {31'd0, done}, 32'd1);
        for (int i = 0; i < 4; i++) step(1'b1, 32'd900);

        // post_len = 15: pre_len = 1, so the second write may trigger.
        rearm(15);
        step(1'b1, 32'd200);
        step(1'b1, 32'd300);
        check("plmax_trig_addr", {28'd0, status_word[3:0]}, 32'd1);
        run_to_done(80);

        // Randomized sessions with random threshold, post_len, force and arm drops.
        for (int s = 0; s < 8; s++) begin
            threshold = $urandom_range(0, 255);
            rearm($urandom_range(0, 15));
            for (int i = 0; i < 60; i++) begin
                ctrl_word[0] = 1'($urandom_range(0, 49) != 0);
                ctrl_word[1] = 1'($urandom_range(0, 29) == 0);
                if ($urandom_range(0, 19) == 0) threshold = $urandom_range(0, 255);
                step(1'($urandom_range(0, 9) < 7), $urandom_range(0, 255));
            end
        end

        // Asynchronous reset in the middle of CAPTURE.
        threshold = 32'd0;
        rearm(8);
        for (int i = 0; i < 10; i++) step(1'b1, 32'(i + 1));
        check("pre_reset_state", {30'd0, status_word[29:28]}, 32'd2);
        #2;
        user_rst_n = 1'b0;
        #1;
        check("async_we", {31'd0, bram_we}, 32'd0);
        check("async_done", {31'd0, done}, 32'd0);
        check("async_status", status_word, 32'd0);
        ctrl_word = 32'd0;
        model_reset();
        @(negedge user_clk);
        user_rst_n = 1'b1;
        step(1'b1, 32'd5);
        check("post_reset_state", {30'd0, status_word[29:28]}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule
